tick_meter: RTL and testbench
=============================

Name: tick_meter

Overview:
- Parametrised successor of the misc-block counter section: N_CH E1 channels of rx/tx tick counters snapshotted on USB SOF, plus a free-running timebase.
- Adds a selectable delta capture mode and an SOF sequence counter.
- Adds a PPS timestamp FIFO with sticky overflow, so firmware cannot lose PPS edges between polls.
- Sits on the Wishbone peripheral bus beside misc. PPS is pre-deglitched upstream.

Parameters:
- N_CH, 2, number of E1 channels (1..8).
- CW, 16, tick counter width (1..32).
- TW, 32, timebase width (1..32).
- FIFO_LOG, 3, log2 of the PPS FIFO depth (1..5).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- tick_rx  in  N_CH  one-cycle rx tick pulses, one per channel.
- tick_tx  in  N_CH  one-cycle tx tick pulses, one per channel.
- tick_sof  in  1  one-cycle USB SOF pulse (capture strobe).
- pps_rise  in  1  one-cycle filtered PPS rising edge.
- wb_addr  in  8  word address.
- wb_rdata  out  32  registered read data.
- wb_wdata  in  32  write data.
- wb_we  in  1  write enable.
- wb_cyc  in  1  cycle.
- wb_ack  out  1  acknowledge.
- irq  out  1  registered: irq_en AND FIFO not empty.

Behaviour:
- Reset: every counter, capture, CTRL bit, FIFO pointer and the overflow flag go to 0. Outputs wb_ack=0, wb_rdata=0, irq=0.
- Bus handshake:
  - wb_ack <= wb_cyc & ~wb_ack, so every access completes in exactly 2 cycles.
  - wb_rdata is valid only while ack is high and is 0 otherwise.
  - Writes and pops take effect on the ack cycle, once per access.
- Register map (word addresses). Unmapped addresses read 0; writes to them are ignored.
  - 0x00 CTRL (rw):
    - [0] delta.
    - [8] irq_en.
    - [1] flush: write-1 strobe, reads 0, empties the FIFO.
  - 0x01 STATUS (r):
    - [5:0] FIFO level.
    - [16] empty.
    - [17] full.
    - [18] ovf. Write 1 to bit 18 of STATUS to clear ovf.
  - 0x02 TIME (r): live timebase, zero-extended.
  - 0x03 PPS_POP (r): returns the FIFO head and pops it. When empty, returns 0 and nothing changes.
  - 0x04 SOF_SEQ (r): 16-bit SOF count, wraps.
  - 0x10+2*ch RXCAP (r), and 0x11+2*ch TXCAP (r), for ch < N_CH. Captures are zero-extended.
- Counters:
  - Timebase increments every cycle and wraps mod 2^TW.
  - Tick counters increment by 1 on their tick and wrap mod 2^CW.
  - Counters are never cleared by a capture.
- On tick_sof:
  - If delta=0, cap <= counter register value before this cycle's update. A tick in the same cycle is not included in this capture; it appears in the next one.
  - If delta=1, cap <= (counter register − prev) mod 2^CW, where prev is updated to the same counter value. prev is tracked in both modes, so switching mode gives an immediately valid delta.
  - SOF_SEQ increments.
- PPS FIFO:
  - On pps_rise, push the timebase register value if the FIFO is not full.
  - If full: drop the new value, keep existing contents and set ovf (sticky).
- FIFO simultaneous events:
  - Push and pop in the same cycle: both occur. When full, the pop frees the slot and the push is accepted with no ovf.
  - Flush and push in the same cycle: flush wins; FIFO ends empty and ovf is unchanged.
  - Pointers wrap mod 2^FIFO_LOG and the level saturates at the depth.
- Bus/capture collision: a capture register read in the same cycle as a tick_sof update returns the pre-update value.
- Reset mid-access: reset forces wb_ack=0. A pop in flight is lost with no FIFO change.

Decomposition:
- Shared package holds register address constants, CTRL/STATUS bit positions and the FIFO_LOG range limit.
- One natural sub-module: tick_meter_fifo, a synchronous FIFO with width TW and depth 2^FIFO_LOG. Ports: push, pop, flush, level, full, empty. FIFO storage is not reset; only pointers are.
- The per-channel counter/capture pair is a generate loop, not a module.

Test Plan:
- Absolute capture: 5 rx ticks on ch0, then tick_sof with a 6th tick in the same cycle → RXCAP0=5. Second SOF with no ticks → 6. SOF_SEQ=2.
- Delta mode wrap: CW=4, delta=1; 14 ticks, SOF (cap 14); then 5 ticks, SOF → cap 5 (counter wrapped 15→3).
- PPS FIFO order: pps_rise at times T0, T1, T2 → STATUS level=3; pops return T0, T1, T2, then the 4th pop returns 0 with level 0.
- Overflow: FIFO_LOG=1; 3 pps_rise pulses → level 2, full=1, ovf=1, head=first timestamp. Write STATUS bit 18 → ovf=0.
- Collisions:
  - pps_rise on the same cycle as a pop with FIFO full → level stays 2 and ovf stays 0.
  - pps_rise coincident with flush → level 0.
- irq and reset: irq_en=1 with one entry → irq=1 one cycle after the push, 0 one cycle after the pop. Asserting rst mid-access → wb_ack drops at once, all registers read 0 after reset.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// Shared constants for tick_meter: register map, CTRL/STATUS bit positions and FIFO limits.
package tick_meter_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h01;
    localparam logic [7:0] ADDR_TIME     = 8'h02;
    localparam logic [7:0] ADDR_PPS_POP  = 8'h03;
    localparam logic [7:0] ADDR_SOF_SEQ  = 8'h04;
    localparam logic [7:0] ADDR_CAP_BASE = 8'h10;

    localparam int unsigned CTRL_DELTA_BIT  = 0;
    localparam int unsigned CTRL_FLUSH_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 8;

    localparam int unsigned STAT_LEVEL_W    = 6;
    localparam int unsigned STAT_EMPTY_BIT  = 16;
    localparam int unsigned STAT_FULL_BIT   = 17;
    localparam int unsigned STAT_OVF_BIT    = 18;

    localparam int unsigned FIFO_LOG_MAX    = 5;
    localparam int unsigned SOF_SEQ_W       = 16;

    function automatic logic [31:0] status_word(input logic [STAT_LEVEL_W-1:0] level,
                                                input logic empty,
                                                input logic full,
                                                input logic ovf);
        logic [31:0] w;
        w                     = '0;
        w[STAT_LEVEL_W-1:0]   = level;
        w[STAT_EMPTY_BIT]     = empty;
        w[STAT_FULL_BIT]      = full;
        w[STAT_OVF_BIT]       = ovf;
        return w;
    endfunction

endpackage

// File: rtl/tick_meter_fifo.sv
// Synchronous FIFO for PPS timestamps; flush overrides push/pop, storage is not reset.
module tick_meter_fifo #(
    parameter int unsigned W   = 32,
    parameter int unsigned LOG = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [LOG:0] o_level,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned DEPTH = 1 << LOG;
    localparam int unsigned CNT_W = LOG + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [LOG-1:0]   r_wr_ptr;
    logic [LOG-1:0]   r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A pop on a full FIFO frees the slot for a same-cycle push.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LOG'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + LOG'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_meter.sv
// E1 rx/tx tick counters captured on USB SOF, free-running timebase and PPS timestamp FIFO on Wishbone.
module tick_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CW       = 16,
    parameter int unsigned TW       = 32,
    parameter int unsigned FIFO_LOG = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] tick_rx,
    input  logic [N_CH-1:0] tick_tx,
    input  logic            tick_sof,
    input  logic            pps_rise,
    input  logic [7:0]      wb_addr,
    output logic [31:0]     wb_rdata,
    input  logic [31:0]     wb_wdata,
    input  logic            wb_we,
    input  logic            wb_cyc,
    output logic            wb_ack,
    output logic            irq
);

    localparam int unsigned FL = (FIFO_LOG > FIFO_LOG_MAX) ? FIFO_LOG_MAX : FIFO_LOG;

    logic                 r_ack;
    logic [31:0]          r_rdata;
    logic                 r_irq;
    logic                 r_delta;
    logic                 r_irq_en;
    logic                 r_ovf;
    logic [TW-1:0]        r_time;
    logic [SOF_SEQ_W-1:0] r_sof_seq;

    logic                 w_acc;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_ovf_set;
    logic [TW-1:0]        w_head;
    logic [FL:0]          w_level;
    logic                 w_full;
    logic                 w_empty;
    logic [31:0]          w_rd_data;
    logic [N_CH-1:0][CW-1:0] w_rx_cap;
    logic [N_CH-1:0][CW-1:0] w_tx_cap;
    logic                 w_unused;

    assign w_unused  = ^{wb_wdata[31:19], wb_wdata[17:9], wb_wdata[7:2]};

    // Access strobe: the cycle whose edge raises ack, so each access acts exactly once.
    assign w_acc     = wb_cyc & ~r_ack;
    assign w_wr      = w_acc & wb_we;
    assign w_pop     = w_acc & ~wb_we & (wb_addr == ADDR_PPS_POP);
    assign w_flush   = w_wr & (wb_addr == ADDR_CTRL) & wb_wdata[CTRL_FLUSH_BIT];
    assign w_ovf_set = pps_rise & w_full & ~w_pop & ~w_flush;

    tick_meter_fifo #(
        .W   (TW),
        .LOG (FL)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (pps_rise),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (r_time),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Per-channel counters; prev tracks in both modes so a mode switch yields a valid delta.
    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        logic [CW-1:0] r_rx_cnt, r_rx_prev, r_rx_cap;
        logic [CW-1:0] r_tx_cnt, r_tx_prev, r_tx_cap;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rx_cnt  <= '0;
                r_rx_prev <= '0;
                r_rx_cap  <= '0;
                r_tx_cnt  <= '0;
                r_tx_prev <= '0;
                r_tx_cap  <= '0;
            end else begin
                r_rx_cnt <= r_rx_cnt + CW'(tick_rx[g]);
                r_tx_cnt <= r_tx_cnt + CW'(tick_tx[g]);
                if (tick_sof) begin
                    r_rx_cap  <= r_delta ? (r_rx_cnt - r_rx_prev) : r_rx_cnt;
                    r_tx_cap  <= r_delta ? (r_tx_cnt - r_tx_prev) : r_tx_cnt;
                    r_rx_prev <= r_rx_cnt;
                    r_tx_prev <= r_tx_cnt;
                end
            end
        end

        assign w_rx_cap[g] = r_rx_cap;
        assign w_tx_cap[g] = r_tx_cap;
    end

    always_comb begin
        w_rd_data = '0;
        case (wb_addr)
            ADDR_CTRL: begin
                w_rd_data[CTRL_DELTA_BIT]  = r_delta;
                w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            ADDR_STATUS:  w_rd_data = status_word(STAT_LEVEL_W'(w_level), w_empty, w_full, r_ovf);
            ADDR_TIME:    w_rd_data = 32'(r_time);
            ADDR_PPS_POP: w_rd_data = w_empty ? 32'd0 : 32'(w_head);
            ADDR_SOF_SEQ: w_rd_data = 32'(r_sof_seq);
            default: ;
        endcase
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (wb_addr == 8'(ADDR_CAP_BASE + 2 * ch)) begin
                w_rd_data = 32'(w_rx_cap[ch]);
            end
            if (wb_addr == 8'(ADDR_CAP_BASE + 2 * ch + 1)) begin
                w_rd_data = 32'(w_tx_cap[ch]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
            r_delta   <= 1'b0;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
            r_time    <= '0;
            r_sof_seq <= '0;
        end else begin
            r_ack   <= wb_cyc & ~r_ack;
            r_rdata <= w_acc ? w_rd_data : 32'd0;
            r_irq   <= r_irq_en & ~w_empty;
            r_time  <= r_time + TW'(1);
            if (tick_sof) begin
                r_sof_seq <= r_sof_seq + SOF_SEQ_W'(1);
            end
            if (w_wr && (wb_addr == ADDR_CTRL)) begin
                r_delta  <= wb_wdata[CTRL_DELTA_BIT];
                r_irq_en <= wb_wdata[CTRL_IRQ_EN_BIT];
            end
            // A same-cycle overflow beats the firmware clear so no drop goes unreported.
            if (w_wr && (wb_addr == ADDR_STATUS) && wb_wdata[STAT_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign wb_ack   = r_ack;
    assign wb_rdata = r_rdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_tick_meter.sv
// Directed bench for tick_meter: instance A uses defaults, instance B uses CW=4, FIFO_LOG=1.
module tb_tick_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  tick_rx = '0;
    logic [1:0]  tick_tx = '0;
    logic        tick_sof = 1'b0;
    logic        pps_rise = 1'b0;
    logic [7:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_we = 1'b0;
    logic        cyc_a = 1'b0;
    logic        cyc_b = 1'b0;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, irq_a, irq_b;

    logic [31:0] tb_time;
    logic [31:0] t_issue;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    // Reference timebase: cycles since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_time <= '0;
        else     tb_time <= tb_time + 32'd1;
    end

    tick_meter #(.N_CH(2), .CW(16), .TW(32), .FIFO_LOG(3)) dut_a (
        .clk(clk), .rst(rst), .tick_rx(tick_rx), .tick_tx(tick_tx),
        .tick_sof(tick_sof), .pps_rise(pps_rise), .wb_addr(wb_addr),
        .wb_rdata(rdata_a), .wb_wdata(wb_wdata), .wb_we(wb_we),
        .wb_cyc(cyc_a), .wb_ack(ack_a), .irq(irq_a)
    );

    tick_meter #(.N_CH(1), .CW(4), .TW(32), .FIFO_LOG(1)) dut_b (
        .clk(clk), .rst(rst), .tick_rx(tick_rx[0:0]), .tick_tx(tick_tx[0:0]),
        .tick_sof(tick_sof), .pps_rise(pps_rise), .wb_addr(wb_addr),
        .wb_rdata(rdata_b), .wb_wdata(wb_wdata), .wb_we(wb_we),
        .wb_cyc(cyc_b), .wb_ack(ack_b), .irq(irq_b)
    );

    task automatic bus(input bit sel, input logic [7:0] addr, input bit we,
                       input logic [31:0] wd, input bit pps_x, input bit sof_x,
                       output logic [31:0] rd);
        @(posedge clk); #1;
        wb_addr = addr; wb_we = we; wb_wdata = wd;
        if (sel) cyc_b = 1'b1; else cyc_a = 1'b1;
        pps_rise = pps_x; tick_sof = sof_x;
        t_issue = tb_time;
        @(posedge clk); #1;
        rd = sel ? rdata_b : rdata_a;
        cyc_a = 1'b0; cyc_b = 1'b0; wb_we = 1'b0;
        pps_rise = 1'b0; tick_sof = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [7:0] addr, output logic [31:0] v);
        bus(sel, addr, 1'b0, 32'd0, 1'b0, 1'b0, v);
    endtask

    task automatic wr(input bit sel, input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(sel, addr, 1'b1, wd, 1'b0, 1'b0, dummy);
    endtask

    task automatic ticks(input int n, input logic [1:0] rx, input logic [1:0] tx);
        repeat (n) begin
            @(posedge clk); #1;
            tick_rx = rx; tick_tx = tx;
        end
        @(posedge clk); #1;
        tick_rx = '0; tick_tx = '0;
    endtask

    task automatic sof_pulse(input logic [1:0] rx);
        @(posedge clk); #1;
        tick_sof = 1'b1; tick_rx = rx;
        @(posedge clk); #1;
        tick_sof = 1'b0; tick_rx = '0;
    endtask

    task automatic pps_pulse(output logic [31:0] ts);
        @(posedge clk); #1;
        pps_rise = 1'b1; ts = tb_time;
        @(posedge clk); #1;
        pps_rise = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ack_a !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack_a); else passed++;
        total++; if (rdata_a !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rdata_a); else passed++;
        total++; if (irq_a !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_a); else passed++;
    endtask

    task automatic test_abs_capture();
        logic [31:0] v;
        do_reset();
        ticks(5, 2'b01, 2'b10);
        sof_pulse(2'b01);
        rd(1'b0, 8'h10, v);
        total++; if (v !== 32'd5) $display("FAIL abs_rxcap0: got %0d want 5", v); else passed++;
        rd(1'b0, 8'h13, v);
        total++; if (v !== 32'd5) $display("FAIL abs_txcap1: got %0d want 5", v); else passed++;
        sof_pulse(2'b00);
        rd(1'b0, 8'h10, v);
        total++; if (v !== 32'd6) $display("FAIL abs_rxcap0_2nd: got %0d want 6", v); else passed++;
        rd(1'b0, 8'h04, v);
        total++; if (v !== 32'd2) $display("FAIL sof_seq: got %0d want 2", v); else passed++;
        ticks(3, 2'b01, 2'b00);
        bus(1'b0, 8'h10, 1'b0, 32'd0, 1'b0, 1'b1, v);
        total++; if (v !== 32'd6) $display("FAIL cap_collision_pre: got %0d want 6", v); else passed++;
        rd(1'b0, 8'h10, v);
        total++; if (v !== 32'd9) $display("FAIL cap_collision_post: got %0d want 9", v); else passed++;
        rd(1'b0, 8'h05, v);
        total++; if (v !== 32'd0) $display("FAIL unmapped_05: got %h want 0", v); else passed++;
        rd(1'b0, 8'h15, v);
        total++; if (v !== 32'd0) $display("FAIL unmapped_15: got %h want 0", v); else passed++;
    endtask

    task automatic test_delta_wrap();
        logic [31:0] v;
        do_reset();
        wr(1'b1, 8'h00, 32'h0000_0001);
        rd(1'b1, 8'h00, v);
        total++; if (v !== 32'h1) $display("FAIL delta_ctrl: got %h want 1", v); else passed++;
        ticks(14, 2'b01, 2'b00);
        sof_pulse(2'b00);
        rd(1'b1, 8'h10, v);
        total++; if (v !== 32'd14) $display("FAIL delta_first: got %0d want 14", v); else passed++;
        ticks(5, 2'b01, 2'b00);
        sof_pulse(2'b00);
        rd(1'b1, 8'h10, v);
        total++; if (v !== 32'd5) $display("FAIL delta_wrap: got %0d want 5", v); else passed++;
        rd(1'b0, 8'h10, v);
        total++; if (v !== 32'd19) $display("FAIL abs_side_by_side: got %0d want 19", v); else passed++;
    endtask

    task automatic test_pps_order();
        logic [31:0] v, t0, t1, t2;
        do_reset();
        rd(1'b0, 8'h02, v);
        total++; if (v !== t_issue) $display("FAIL time_read: got %0d want %0d", v, t_issue); else passed++;
        pps_pulse(t0);
        repeat (3) @(posedge clk);
        pps_pulse(t1);
        repeat (5) @(posedge clk);
        pps_pulse(t2);
        rd(1'b0, 8'h01, v);
        total++; if (v !== 32'h0000_0003) $display("FAIL pps_level3: got %h want 00000003", v); else passed++;
        rd(1'b0, 8'h03, v);
        total++; if (v !== t0) $display("FAIL pps_pop0: got %0d want %0d", v, t0); else passed++;
        rd(1'b0, 8'h03, v);
        total++; if (v !== t1) $display("FAIL pps_pop1: got %0d want %0d", v, t1); else passed++;
        rd(1'b0, 8'h03, v);
        total++; if (v !== t2) $display("FAIL pps_pop2: got %0d want %0d", v, t2); else passed++;
        rd(1'b0, 8'h03, v);
        total++; if (v !== 32'd0) $display("FAIL pps_pop_empty: got %0d want 0", v); else passed++;
        rd(1'b0, 8'h01, v);
        total++; if (v !== 32'h0001_0000) $display("FAIL pps_status_empty: got %h want 00010000", v); else passed++;
    endtask

    task automatic test_overflow_collisions();
        logic [31:0] v, t0, t1, t2, tx;
        do_reset();
        pps_pulse(t0);
        pps_pulse(t1);
        pps_pulse(t2);
        rd(1'b1, 8'h01, v);
        total++; if (v !== 32'h0006_0002) $display("FAIL ovf_status: got %h want 00060002", v); else passed++;
        wr(1'b1, 8'h01, 32'h0004_0000);
        rd(1'b1, 8'h01, v);
        total++; if (v !== 32'h0002_0002) $display("FAIL ovf_clear: got %h want 00020002", v); else passed++;
        bus(1'b1, 8'h03, 1'b0, 32'd0, 1'b1, 1'b0, v);
        total++; if (v !== t0) $display("FAIL pop_push_head: got %0d want %0d", v, t0); else passed++;
        rd(1'b1, 8'h01, v);
        total++; if (v !== 32'h0002_0002) $display("FAIL pop_push_status: got %h want 00020002", v); else passed++;
        rd(1'b1, 8'h03, v);
        total++; if (v !== t1) $display("FAIL pop_after_collision: got %0d want %0d", v, t1); else passed++;
        pps_pulse(tx);
        pps_pulse(tx);
        rd(1'b1, 8'h01, v);
        total++; if (v !== 32'h0006_0002) $display("FAIL ovf_again: got %h want 00060002", v); else passed++;
        bus(1'b1, 8'h00, 1'b1, 32'h0000_0002, 1'b1, 1'b0, v);
        rd(1'b1, 8'h01, v);
        total++; if (v !== 32'h0005_0000) $display("FAIL flush_push: got %h want 00050000", v); else passed++;
    endtask

    task automatic test_irq();
        logic [31:0] v, t0;
        do_reset();
        wr(1'b0, 8'h00, 32'h0000_0100);
        pps_pulse(t0);
        total++; if (irq_a !== 1'b0) $display("FAIL irq_at_push: got %b want 0", irq_a); else passed++;
        @(posedge clk); #1;
        total++; if (irq_a !== 1'b1) $display("FAIL irq_after_push: got %b want 1", irq_a); else passed++;
        rd(1'b0, 8'h03, v);
        total++; if (irq_a !== 1'b1) $display("FAIL irq_at_pop: got %b want 1", irq_a); else passed++;
        @(posedge clk); #1;
        total++; if (irq_a !== 1'b0) $display("FAIL irq_after_pop: got %b want 0", irq_a); else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] v;
        wr(1'b0, 8'h00, 32'h0000_0101);
        sof_pulse(2'b01);
        @(posedge clk); #1;
        wb_addr = 8'h00; wb_we = 1'b0; cyc_a = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (ack_a !== 1'b0) $display("FAIL rst_mid_ack: got %b want 0", ack_a); else passed++;
        total++; if (rdata_a !== 32'd0) $display("FAIL rst_mid_rdata: got %h want 0", rdata_a); else passed++;
        cyc_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd(1'b0, 8'h00, v);
        total++; if (v !== 32'd0) $display("FAIL post_rst_ctrl: got %h want 0", v); else passed++;
        rd(1'b0, 8'h01, v);
        total++; if (v !== 32'h0001_0000) $display("FAIL post_rst_status: got %h want 00010000", v); else passed++;
        rd(1'b0, 8'h04, v);
        total++; if (v !== 32'd0) $display("FAIL post_rst_sofseq: got %h want 0", v); else passed++;
        rd(1'b0, 8'h10, v);
        total++; if (v !== 32'd0) $display("FAIL post_rst_rxcap0: got %h want 0", v); else passed++;
        total++; if (irq_a !== 1'b0) $display("FAIL post_rst_irq: got %b want 0", irq_a); else passed++;
    endtask

    initial begin
        test_reset();
        test_abs_capture();
        test_delta_wrap();
        test_pps_order();
        test_overflow_collisions();
        test_irq();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
